// File: rtl/twos_comp_serial_ctrl.sv
// rtl/twos_comp_serial_ctrl.sv - sequencing controller for the bit-serial two's-complement core
//
// Purpose:
//   Accepts a parallel WIDTH-bit operand, pulses a clear into the shared
//   serial core, streams the operand LSB-first into it, reassembles the
//   serial result and returns it with an overflow flag.
//
// Ports:
//   clk        rising-edge clock (also clocks the serial core)
//   rst        asynchronous active-low reset
//   in_valid   producer has a word on in_data
//   in_ready   controller can accept a word (IDLE only)
//   in_data    operand, sampled on in_valid & in_ready
//   out_valid  out_data / out_ovf are valid
//   out_ready  consumer accepts the result
//   out_data   two's complement of the operand, modulo 2^WIDTH
//   out_ovf    operand was the most-negative value
//   busy       high in CLEAR, SHIFT and DONE
//   ser_clr    active-high clear to the core, one-cycle registered pulse
//   ser_in     serial bit to the core incode
//   ser_out    core outcode (combinational in ser_in and core state)

module twos_comp_serial_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy,
  output logic             ser_clr,
  output logic             ser_in,
  input  logic             ser_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   res_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   out_data_q;
  logic               out_ovf_q;
  logic               busy_q;
  logic               ser_clr_q;
  logic               ser_in_q;

  // Result word as it stands after capturing the current serial bit.
  logic [WIDTH-1:0]   res_d;
  assign res_d = {ser_out, res_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      opnd_q      <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      busy_q      <= 1'b0;
      // Held high through reset so the core is cleared as well.
      ser_clr_q   <= 1'b1;
      ser_in_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ser_in_q <= 1'b0;
          if (in_valid && in_ready_q) begin
            opnd_q     <= in_data;
            res_q      <= '0;
            out_ovf_q  <= (in_data == MOST_NEG);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            ser_clr_q  <= 1'b1;
            state_q    <= CLEAR;
          end else begin
            ser_clr_q  <= 1'b0;
          end
        end

        CLEAR: begin
          // The core clears at the edge ending this cycle; bit 0 is
          // presented in the first SHIFT cycle.
          ser_clr_q <= 1'b0;
          cnt_q     <= '0;
          ser_in_q  <= opnd_q[0];
          state_q   <= SHIFT;
        end

        SHIFT: begin
          res_q  <= res_d;
          opnd_q <= opnd_q >> 1;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            ser_in_q    <= 1'b0;
            out_data_q  <= res_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            // opnd_q[1] becomes the LSB after this edge's shift.
            ser_in_q    <= opnd_q[1];
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          ser_in_q    <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = busy_q;
  assign ser_clr   = ser_clr_q;
  assign ser_in    = ser_in_q;

endmodule
